// File: rtl/lcd_timing.sv
// LCD display timing generator: dot/char/line counters, LP/YD strobes, active flag and VRAM fetch strobe.
// Optional LCDT_FR_EN adds the AC-drive (fr) output, toggled once per frame.
module lcd_timing #(
    parameter int CW = 8,
    parameter int LW = 8
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          disp_on,
    input  logic [CW-1:0] reg_tcr,
    input  logic [CW-1:0] reg_cr,
    input  logic [LW-1:0] reg_lf,
    input  logic [2:0]    reg_fx,
    output logic [CW-1:0] char_cnt,
    output logic [LW-1:0] line_cnt,
    output logic [2:0]    dot_cnt,
    output logic          lp,
    output logic          yd,
    output logic          active,
    output logic          fetch_req,
    output logic          fr
);

    typedef struct packed {
        logic [CW-1:0] tcr;
        logic [CW-1:0] cr;
        logic [LW-1:0] lf;
        logic [2:0]    fx;
    } geom_t;

    geom_t         shd;
    geom_t         geom_in;
    logic [CW-1:0] c_char;
    logic [LW-1:0] c_line;
    logic [2:0]    c_dot;
    logic [CW:0]   cr_inc;
    logic [CW-1:0] tcr_eff;
    logic          char_tick;
    logic          row_end;
    logic          frame_end;
    logic          c_act;

    assign geom_in = '{tcr: reg_tcr, cr: reg_cr, lf: reg_lf, fx: reg_fx};

    // Row always ends at least one char past the active span, unless cr is already all-ones.
    always_comb begin
        cr_inc  = {1'b0, shd.cr} + {{CW{1'b0}}, 1'b1};
        tcr_eff = (shd.tcr > shd.cr) ? shd.tcr
                : (cr_inc[CW] ? {CW{1'b1}} : cr_inc[CW-1:0]);
    end

    assign char_tick = (c_dot == shd.fx);
    assign row_end   = char_tick && (c_char == tcr_eff);
    assign frame_end = row_end && (c_line == shd.lf);
    assign c_act     = (c_char <= shd.cr) && (c_line <= shd.lf);

    always_ff @(posedge clk) begin
        if (rst) begin
            shd       <= '0;
            c_dot     <= '0;
            c_char    <= '0;
            c_line    <= '0;
            dot_cnt   <= '0;
            char_cnt  <= '0;
            line_cnt  <= '0;
            lp        <= 1'b0;
            yd        <= 1'b0;
            active    <= 1'b0;
            fetch_req <= 1'b0;
        end else if (!disp_on) begin
            shd       <= geom_in;
            c_dot     <= '0;
            c_char    <= '0;
            c_line    <= '0;
            dot_cnt   <= '0;
            char_cnt  <= '0;
            line_cnt  <= '0;
            lp        <= 1'b0;
            yd        <= 1'b0;
            active    <= 1'b0;
            fetch_req <= 1'b0;
        end else begin
            // Outputs decode the counter state of this cycle, one clk later.
            dot_cnt   <= c_dot;
            char_cnt  <= c_char;
            line_cnt  <= c_line;
            lp        <= row_end;
            yd        <= (c_line == '0);
            active    <= c_act;
            fetch_req <= c_act && (c_dot == 3'd0);

            if (char_tick) begin
                c_dot <= '0;
                if (row_end) begin
                    c_char <= '0;
                    c_line <= frame_end ? '0 : c_line + 1'b1;
                end else begin
                    c_char <= c_char + 1'b1;
                end
            end else begin
                c_dot <= c_dot + 1'b1;
            end

            if (frame_end)
                shd <= geom_in;
        end
    end

`ifdef LCDT_FR_EN
    always_ff @(posedge clk) begin
        if (rst)
            fr <= 1'b0;
        else if (disp_on && frame_end)
            fr <= ~fr;
    end
`else
    assign fr = 1'b0;
`endif

endmodule
